alu_decode_issue: RTL
=====================

# alu_decode_issue

Decode-and-issue stage that feeds the combinational ALU. Accepts RV32I OP and OP-IMM instructions, plus LUI, over a valid/ready stream. Decodes each into the ALU's 4-bit `aluOutSel` encoding, reads operands from an internal 32x32 register file and presents them to the ALU through a registered issue stage. Takes the ALU result back and writes it to `rd` when the issue handshake fires.

## Interface
Parameters:
- `CNT_W`, 8: width of the saturating illegal-instruction counter.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction word.
- `instrValid`  in  1  `instr` valid.
- `instrReady`  out  1  stage can accept `instr` this cycle.
- `opA`  out  32  ALU operand A.
- `opB`  out  32  ALU operand B.
- `aluOutSel`  out  4  ALU operation select.
- `aluValid`  out  1  issue register holds a valid op.
- `aluReady`  in  1  ALU/downstream consumes the op this cycle.
- `aluIn`  in  32  ALU result for the op currently presented (combinational return).
- `illegal`  out  1  one-cycle pulse: an unsupported instruction was consumed.
- `illegalCnt`  out  CNT_W  saturating count of illegal instructions.
- `dbgAddr`  in  5  register-file debug read address.
- `dbgData`  out  32  `regfile[dbgAddr]`, combinational.

## Operation
- Select encoding: 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1111 PASS (result = `opA`).
- OP (0110011): funct3/funct7 map as follows; `opB` = `regfile[rs2]`.
  - 000/0000000 ADD; 000/0100000 SUB.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101/0000000 SRL; 101/0100000 SRA.
  - 110 OR; 111 AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): same mapping with `opB` = sign-extended imm[11:0]. No SUBI.
  - Shifts use `opB` = {27'b0, shamt}.
  - SRAI is selected by instr[30]; instr[31] or instr[29:25] nonzero on a shift is illegal.
- LUI (0110111): select 1111, `opA` = {instr[31:12], 12'b0}, `opB` = 0.
- Any other opcode is illegal: consumed, never issued, `illegal` pulses, `illegalCnt` increments and holds at all-ones.
- Writeback: on `aluValid && aluReady`, `regfile[rd] <= aluIn` unless rd==0. x0 always reads 0.

## Timing
- Reset: `aluValid`, `opA`, `opB`, `aluOutSel`, `illegal`, `illegalCnt` are 0; all registers clear to 0.
- `instrReady` is 1 after reset.
- Reset mid-operation drops the in-flight op with no writeback.
- Handshake and latency:
  - Accept on `instrValid && instrReady`; the op appears on `aluValid` next cycle (latency 1).
  - Writeback completes on the fire edge.
- Base ready rule: `instrReady = !aluValid || aluReady`, qualified by the hazard rule below.
- Stall: `aluValid && !aluReady` holds `opA`/`opB`/`aluOutSel` stable. `aluIn` must be stable for the held op.
- Hazard: incoming rs1/rs2 (rs2 for OP only) equals the issue-stage rd, with rd≠0 and `aluValid` set.
- Back-to-back dependent ops: with forwarding, 1 op/cycle. Without forwarding, one bubble.
- `illegal` is asserted the cycle after the illegal instruction is accepted.
- Illegal acceptance obeys the same ready rule.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: on a hazard accepted in the same cycle the issue stage fires, the matching operand takes `aluIn`. No stall.
- `ALU_ISSUE_FWD_EN` undefined: `instrReady` = 0 while a hazard exists. The instruction is accepted the cycle after writeback and reads the updated register file.

## Structure
- Shared package `alu_pkg`:
  - `alu_sel_t` enum holding the 4-bit encodings above, also used by the ALU.
  - Opcode constants `OPC_OP`, `OPC_OPIMM`, `OPC_LUI`.
- Sub-module `alu_decoder`: pure combinational; `instr` → {sel, rs1, rs2, rd, imm, useImm, isLui, illegal}.
- The register file, issue register, hazard logic and counter live in the top level.

## Test plan
- Basic ADDI and forwarding: ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, `aluReady`=1.
  - With forwarding: second op issues at cycle 2 with opA=opB=5, and `dbgData`(x2)=10.
  - Without forwarding: one bubble, same final result.
- Signed shift and signed compare: LUI x3,0x80000 then SRAI x4,x3,4 gives x4=0xF8000000. SLT x5,x4,x0 gives x5=1.
- SUB and SRA decode: SUB x6,x1,x1 issues sel 0001 and writes x6=0. An SRA with funct7=0100000 issues sel 1001.
- Illegal opcode 0x00000073: `illegal` pulses one cycle, `illegalCnt`=1, `aluValid` stays 0.
  - 300 illegal words saturate `illegalCnt` at 255.
- Backpressure: hold `aluReady`=0 for 3 cycles with an op pending. `instrReady`=0 and outputs stay stable throughout; no writeback until the fire cycle.
  - ADDI x0,x0,7 issues normally but x0 reads 0.
- Reset mid-op: assert `rst` while `aluValid`=1. Next cycle `aluValid`=0, `instrReady`=1, and all registers read 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select encoding, RV32I opcodes and the
// funct3-to-operation mapping common to OP and OP-IMM.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_PASS = 4'b1111
  } alu_sel_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base operation for a funct3 value; the SUB/SRA variants are picked by funct7.
  function automatic alu_sel_t f3_to_sel(input logic [2:0] f3);
    alu_sel_t sel;
    case (f3)
      3'b000:  sel = ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = ALU_SRL;
      3'b110:  sel = ALU_OR;
      3'b111:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Pure combinational RV32I OP / OP-IMM / LUI decoder producing the ALU select,
// register indices, the immediate and legality.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_sel_t    sel_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic        use_imm_o,
  output logic        is_lui_o,
  output logic        illegal_o
);

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic [4:0] shamt_s;

  assign opcode_s = instr_i[6:0];
  assign f3_s     = instr_i[14:12];
  assign f7_s     = instr_i[31:25];
  assign shamt_s  = instr_i[24:20];
  assign rd_o     = instr_i[11:7];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];

  always_comb begin
    sel_o     = ALU_ADD;
    imm_o     = 32'h0000_0000;
    use_imm_o = 1'b0;
    is_lui_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if ((f3_s == 3'b000) || (f3_s == 3'b101)) begin
          if (f7_s == F7_ALT) begin
            sel_o = (f3_s == 3'b000) ? ALU_SUB : ALU_SRA;
          end else begin
            sel_o     = f3_to_sel(f3_s);
            illegal_o = (f7_s != F7_BASE);
          end
        end else begin
          sel_o     = f3_to_sel(f3_s);
          illegal_o = (f7_s != F7_BASE);
        end
      end
      OPC_OPIMM: begin
        use_imm_o = 1'b1;
        sel_o     = f3_to_sel(f3_s);
        case (f3_s)
          3'b001: begin
            imm_o     = {27'b0, shamt_s};
            illegal_o = (f7_s != F7_BASE);
          end
          // instr[30] chooses SRAI; every other funct7 bit must be clear
          3'b101: begin
            imm_o     = {27'b0, shamt_s};
            sel_o     = instr_i[30] ? ALU_SRA : ALU_SRL;
            illegal_o = instr_i[31] || (instr_i[29:25] != 5'b00000);
          end
          default: begin
            imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
          end
        endcase
      end
      OPC_LUI: begin
        is_lui_o = 1'b1;
        sel_o    = ALU_PASS;
        imm_o    = {instr_i[31:12], 12'h000};
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_issue.sv
// Decode-and-issue stage: register file, single-entry issue register, hazard
// handling and illegal counter. Define ALU_ISSUE_FWD_EN to forward aluIn.
module alu_decode_issue
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instrValid,
  output logic             instrReady,
  output logic [31:0]      opA,
  output logic [31:0]      opB,
  output logic [3:0]       aluOutSel,
  output logic             aluValid,
  input  logic             aluReady,
  input  logic [31:0]      aluIn,
  output logic             illegal,
  output logic [CNT_W-1:0] illegalCnt,
  input  logic [4:0]       dbgAddr,
  output logic [31:0]      dbgData
);

  alu_sel_t    dec_sel_s;
  logic [4:0]  dec_rs1_s;
  logic [4:0]  dec_rs2_s;
  logic [4:0]  dec_rd_s;
  logic [31:0] dec_imm_s;
  logic        dec_use_imm_s;
  logic        dec_is_lui_s;
  logic        dec_illegal_s;

  alu_decoder u_dec (
    .instr_i   (instr),
    .sel_o     (dec_sel_s),
    .rs1_o     (dec_rs1_s),
    .rs2_o     (dec_rs2_s),
    .rd_o      (dec_rd_s),
    .imm_o     (dec_imm_s),
    .use_imm_o (dec_use_imm_s),
    .is_lui_o  (dec_is_lui_s),
    .illegal_o (dec_illegal_s)
  );

  logic [31:0]      rf_q [32];
  logic             valid_q, valid_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  alu_sel_t         sel_q, sel_d;
  logic [4:0]       rd_q, rd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        use_rs1_s, use_rs2_s;
  logic        fire_s, hazard_s, ready_s, accept_s;
  logic        fwd_rs1_s, fwd_rs2_s;
  logic [31:0] rs1_val_s, rs2_val_s;

  assign use_rs1_s = !dec_illegal_s && !dec_is_lui_s;
  assign use_rs2_s = use_rs1_s && !dec_use_imm_s;
  assign fire_s    = valid_q && aluReady;
  assign hazard_s  = valid_q && (rd_q != 5'd0) &&
                     ((use_rs1_s && (dec_rs1_s == rd_q)) ||
                      (use_rs2_s && (dec_rs2_s == rd_q)));

`ifdef ALU_ISSUE_FWD_EN
  // A dependent op may enter only while the producer fires, so aluIn is its result.
  assign ready_s   = !valid_q || aluReady;
  assign fwd_rs1_s = fire_s && (rd_q != 5'd0) && (dec_rs1_s == rd_q);
  assign fwd_rs2_s = fire_s && (rd_q != 5'd0) && (dec_rs2_s == rd_q);
`else
  assign ready_s   = (!valid_q || aluReady) && !hazard_s;
  assign fwd_rs1_s = 1'b0;
  assign fwd_rs2_s = 1'b0;
`endif

  assign accept_s = instrValid && ready_s;

  assign rs1_val_s = fwd_rs1_s ? aluIn :
                     (dec_rs1_s == 5'd0) ? 32'h0000_0000 : rf_q[dec_rs1_s];
  assign rs2_val_s = fwd_rs2_s ? aluIn :
                     (dec_rs2_s == 5'd0) ? 32'h0000_0000 : rf_q[dec_rs2_s];

  // Issue register, illegal pulse and saturating counter next state.
  always_comb begin
    valid_d   = valid_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    if (accept_s && !dec_illegal_s) begin
      valid_d = 1'b1;
      sel_d   = dec_sel_s;
      rd_d    = dec_rd_s;
      op_a_d  = dec_is_lui_s ? dec_imm_s : rs1_val_s;
      if (dec_is_lui_s) begin
        op_b_d = 32'h0000_0000;
      end else if (dec_use_imm_s) begin
        op_b_d = dec_imm_s;
      end else begin
        op_b_d = rs2_val_s;
      end
    end else if (fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (accept_s && dec_illegal_s) begin
      illegal_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      illegal_d = 1'b0;
    end
  end

  // State registers and register-file writeback on the issue handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_a_q    <= 32'h0000_0000;
      op_b_q    <= 32'h0000_0000;
      sel_q     <= ALU_ADD;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0000_0000;
      end
    end else begin
      valid_q   <= valid_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      if (fire_s && (rd_q != 5'd0)) begin
        rf_q[rd_q] <= aluIn;
      end
    end
  end

  assign instrReady = ready_s;
  assign aluValid   = valid_q;
  assign opA        = op_a_q;
  assign opB        = op_b_q;
  assign aluOutSel  = sel_q;
  assign illegal    = illegal_q;
  assign illegalCnt = cnt_q;
  assign dbgData    = (dbgAddr == 5'd0) ? 32'h0000_0000 : rf_q[dbgAddr];

endmodule
